// File: rtl/tcp_ack_sched.sv
`default_nettype none
// ============================================================================
// Module   : tcp_ack_sched
// Purpose  : Delayed-ACK scheduler. It coalesces accepted segments, then
//            raises an ACK on timeout, on a pending-count limit or on window
//            growth. Define TCP_ACK_PUSH_EN to let a pushed segment force an
//            immediate ACK.
// Revision : 1.0 - initial release
// ============================================================================
module tcp_ack_sched #(
  parameter int DLY_MAX  = 4,
  parameter int PEND_MAX = 2,
  parameter int WND_THR  = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       seg_acc,
  input  logic       seg_push,
  input  logic [3:0] rcv_nxt,
  input  logic [3:0] rcv_wnd,
  input  logic       ack_gnt,
  output logic       ack_req,
  output logic [3:0] ack_seq,
  output logic [3:0] ack_wnd
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DELAY = 2'd1,
    REQ   = 2'd2,
    BUSY  = 2'd3
  } state_t;

  localparam logic [3:0] c_dly_last = 4'(DLY_MAX - 1);
  localparam logic [3:0] c_pend_max = 4'(PEND_MAX);
  localparam logic [3:0] c_wnd_thr  = 4'(WND_THR);
`ifdef TCP_ACK_PUSH_EN
  localparam logic       c_push_en  = 1'b1;
`else
  localparam logic       c_push_en  = 1'b0;
`endif

  state_t     r_state;
  state_t     w_state_nxt;
  logic [3:0] r_timer;
  logic [2:0] r_pend;
  logic [3:0] r_adv_wnd;
  logic       r_ack_req;
  logic [3:0] r_ack_seq;
  logic [3:0] r_ack_wnd;

  logic [3:0] w_wnd_diff;
  logic       w_grow;
  logic       w_push;
  logic [3:0] w_pend_sum;
  logic [2:0] w_pend_nxt;
  logic       w_enter_req;

  // Window growth is only meaningful when the window actually got larger;
  // the range check keeps the unsigned subtraction from wrapping into a hit.
  assign w_wnd_diff = rcv_wnd - r_adv_wnd;
  assign w_grow     = (rcv_wnd > r_adv_wnd) && (w_wnd_diff >= c_wnd_thr);
  assign w_push     = seg_acc & seg_push & c_push_en;
  assign w_pend_sum = {1'b0, r_pend} + {3'b000, seg_acc};
  assign w_pend_nxt = (w_pend_sum > 4'd7) ? 3'd7 : w_pend_sum[2:0];

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (w_grow || w_push)
          w_state_nxt = REQ;
        else if (seg_acc)
          w_state_nxt = DELAY;
      end
      DELAY: begin
        if ((r_timer == c_dly_last) || (w_pend_sum >= c_pend_max) || w_grow || w_push)
          w_state_nxt = REQ;
      end
      REQ: begin
        if (ack_gnt)
          w_state_nxt = BUSY;
      end
      BUSY: begin
        w_state_nxt = (w_pend_nxt != 3'd0) ? DELAY : IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign w_enter_req = (r_state != REQ) && (w_state_nxt == REQ);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_timer   <= 4'd0;
      r_pend    <= 3'd0;
      r_adv_wnd <= 4'd0;
      r_ack_req <= 1'b0;
      r_ack_seq <= 4'd0;
      r_ack_wnd <= 4'd0;
    end else begin
      r_state   <= w_state_nxt;
      r_ack_req <= (w_state_nxt == REQ);
      if (w_enter_req) begin
        r_ack_seq <= rcv_nxt;
        r_ack_wnd <= rcv_wnd;
        r_pend    <= 3'd0;
        r_timer   <= 4'd0;
      end else begin
        // Segments arriving while an ACK is outstanding are owed a later ACK.
        r_pend  <= w_pend_nxt;
        r_timer <= (r_state == DELAY) ? (r_timer + 4'd1) : 4'd0;
      end
      if ((r_state == REQ) && ack_gnt)
        r_adv_wnd <= r_ack_wnd;
    end
  end

  assign ack_req = r_ack_req;
  assign ack_seq = r_ack_seq;
  assign ack_wnd = r_ack_wnd;

endmodule
`default_nettype wire

// File: tb/tb_tcp_ack_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_tcp_ack_sched
// Purpose  : Self-checking bench for tcp_ack_sched: cycle model plus
//            hand-computed directed expectations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_tcp_ack_sched;

  localparam int DLY_MAX  = 4;
  localparam int PEND_MAX = 2;
  localparam int WND_THR  = 2;
`ifdef TCP_ACK_PUSH_EN
  localparam bit PUSH = 1'b1;
`else
  localparam bit PUSH = 1'b0;
`endif

  logic       clk      = 1'b0;
  logic       rst_n    = 1'b0;
  logic       seg_acc  = 1'b0;
  logic       seg_push = 1'b0;
  logic       ack_gnt  = 1'b0;
  logic [3:0] rcv_nxt  = 4'd0;
  logic [3:0] rcv_wnd  = 4'd0;
  logic       ack_req;
  logic [3:0] ack_seq;
  logic [3:0] ack_wnd;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  tcp_ack_sched #(
    .DLY_MAX (DLY_MAX),
    .PEND_MAX(PEND_MAX),
    .WND_THR (WND_THR)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .seg_acc (seg_acc),
    .seg_push(seg_push),
    .rcv_nxt (rcv_nxt),
    .rcv_wnd (rcv_wnd),
    .ack_gnt (ack_gnt),
    .ack_req (ack_req),
    .ack_seq (ack_seq),
    .ack_wnd (ack_wnd)
  );

  // Model: an outstanding ACK (req), a one-cycle cool-down after a grant,
  // the number of segments owed an ACK and how long the oldest has waited.
  typedef struct packed {
    bit req;
    bit cool;
    int seq;
    int wnd;
    int adv;
    int owed;
    int age;
  } mstate_t;

  mstate_t m = '0;

  function automatic mstate_t step(mstate_t s, bit acc, bit psh, bit gnt, int nxt, int wnd);
    mstate_t n = s;
    int  sum = (s.owed + int'(acc) > 7) ? 7 : s.owed + int'(acc);
    bit  fire;
    if (s.req) begin
      if (gnt) begin
        n.req  = 1'b0;
        n.cool = 1'b1;
        n.adv  = s.wnd;
      end
      n.owed = sum;
    end else if (s.cool) begin
      n.cool = 1'b0;
      n.owed = sum;
      n.age  = 0;
    end else begin
      fire = ((wnd - s.adv) >= WND_THR) || (PUSH && acc && psh) ||
             ((s.owed > 0) && ((s.age == DLY_MAX - 1) || (s.owed + int'(acc) >= PEND_MAX)));
      if (fire) begin
        n.req  = 1'b1;
        n.seq  = nxt;
        n.wnd  = wnd;
        n.owed = 0;
        n.age  = 0;
      end else if (s.owed > 0) begin
        n.age  = s.age + 1;
        n.owed = sum;
      end else begin
        n.owed = sum;
        n.age  = 0;
      end
    end
    return n;
  endfunction

  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n)
        m = '0;
      else
        m = step(m, seg_acc, seg_push, ack_gnt, int'(rcv_nxt), int'(rcv_wnd));
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      chk("model_ack_req", int'(ack_req), int'(m.req));
      chk("model_ack_seq", int'(ack_seq), m.seq);
      chk("model_ack_wnd", int'(ack_wnd), m.wnd);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_req(input int limit, output int n);
    n = 0;
    while (!ack_req && n < limit) begin
      cyc();
      n++;
    end
  endtask

  task automatic grant();
    ack_gnt = 1'b1;
    cyc();
    ack_gnt = 1'b0;
    chk("busy_low", int'(ack_req), 0);
    cyc();
  endtask

  initial begin
    int lat;
    logic [5:0] pat;
    rcv_nxt = 4'd3;
    rcv_wnd = 4'd0;
    cyc();
    cyc();
    chk("rst_req", int'(ack_req), 0);
    chk("rst_seq", int'(ack_seq), 0);
    chk("rst_wnd", int'(ack_wnd), 0);
    rst_n = 1'b1;
    cyc();

    // Single segment: ACK on delay timeout
    seg_acc = 1'b1;
    cyc();
    seg_acc = 1'b0;
    wait_req(20, lat);
    chk("dly_latency", lat, 4);
    chk("dly_seq", int'(ack_seq), 3);
    chk("dly_wnd", int'(ack_wnd), 0);
    grant();

    // Two back-to-back segments hit the pending limit
    rcv_nxt = 4'd5;
    rcv_wnd = 4'd1;
    seg_acc = 1'b1;
    cyc();
    chk("pend_mid_req", int'(ack_req), 0);
    cyc();
    seg_acc = 1'b0;
    chk("pend_req", int'(ack_req), 1);
    chk("pend_seq", int'(ack_seq), 5);
    chk("pend_wnd", int'(ack_wnd), 1);
    grant();

    // Window growth from advertised 1: 2 is not enough, 3 is
    rcv_wnd = 4'd2;
    cyc();
    chk("wnd2_req", int'(ack_req), 0);
    rcv_wnd = 4'd3;
    cyc();
    chk("wnd3_req", int'(ack_req), 1);
    chk("wnd3_wnd", int'(ack_wnd), 3);
    chk("wnd3_seq", int'(ack_seq), 5);

    // Hold the grant off while segments arrive; latched values stay put
    pat = 6'b101101;
    for (int i = 0; i < 6; i++) begin
      seg_acc = pat[i];
      rcv_nxt = 4'(6 + i);
      cyc();
      chk("hold_req", int'(ack_req), 1);
      chk("hold_seq", int'(ack_seq), 5);
      chk("hold_wnd", int'(ack_wnd), 3);
    end
    seg_acc = 1'b0;
    rcv_nxt = 4'd9;
    ack_gnt = 1'b1;
    cyc();
    ack_gnt = 1'b0;
    chk("hold_busy", int'(ack_req), 0);
    cyc();
    chk("hold_delay", int'(ack_req), 0);
    cyc();
    chk("hold_reack", int'(ack_req), 1);
    chk("hold_reack_seq", int'(ack_seq), 9);
    grant();

    // Shrinking window must not trigger; growth of exactly WND_THR does
    rcv_wnd = 4'd1;
    cyc(); cyc(); cyc();
    chk("shrink_req", int'(ack_req), 0);
    rcv_wnd = 4'd4;
    cyc();
    chk("grow1_req", int'(ack_req), 0);
    rcv_wnd = 4'd5;
    cyc();
    chk("grow_thr_req", int'(ack_req), 1);
    chk("grow_thr_wnd", int'(ack_wnd), 5);
    grant();

    // Pushed segment from IDLE
    rcv_nxt  = 4'd2;
    seg_acc  = 1'b1;
    seg_push = 1'b1;
    cyc();
    seg_acc  = 1'b0;
    seg_push = 1'b0;
    wait_req(20, lat);
    chk("push_latency", lat, PUSH ? 0 : DLY_MAX);
    chk("push_seq", int'(ack_seq), 2);
    grant();

    // Reset release with an open window gives an initial window ACK
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    cyc();
    chk("init_req", int'(ack_req), 1);
    chk("init_wnd", int'(ack_wnd), 5);
    // Asynchronous reset mid-cycle while the ACK is up
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_req", int'(ack_req), 0);
    chk("async_seq", int'(ack_seq), 0);
    chk("async_wnd", int'(ack_wnd), 0);
    rcv_wnd = 4'd0;
    cyc();
    rst_n = 1'b1;
    cyc(); cyc(); cyc();
    chk("post_rst_req", int'(ack_req), 0);

    // Eight segments while waiting for the grant: pend must saturate, not wrap
    rcv_wnd = 4'd2;
    cyc();
    chk("sat_req", int'(ack_req), 1);
    seg_acc = 1'b1;
    for (int i = 0; i < 8; i++) cyc();
    seg_acc = 1'b0;
    ack_gnt = 1'b1;
    cyc();
    ack_gnt = 1'b0;
    cyc();
    chk("sat_delay", int'(ack_req), 0);
    cyc();
    chk("sat_reack", int'(ack_req), 1);
    grant();

    // Deterministic mixed sweep, checked by the model every cycle
    for (int i = 0; i < 300; i++) begin
      seg_acc  = (i % 3 == 0);
      seg_push = (i % 4 == 0);
      ack_gnt  = (i % 5 == 2);
      rcv_nxt  = 4'(i % 16);
      rcv_wnd  = 4'((i / 9) % 16);
      cyc();
    end
    seg_acc  = 1'b0;
    seg_push = 1'b0;
    ack_gnt  = 1'b0;
    cyc(); cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
